// File: rtl/ap_pkg.sv
// Shared state encoding and counter sizing for the audio feature-pipeline sequencer.
package ap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } ap_seq_state_t;

    localparam int AP_NUM_FRAMES   = 13;
    localparam int AP_FEAT_LEN     = 2 * AP_NUM_FRAMES;
    localparam int AP_MAX_INFLIGHT = 3;
    localparam int AP_CNT_W        = 4;
    localparam int AP_INFLIGHT_W   = $clog2(AP_MAX_INFLIGHT + 1);

endpackage

// File: rtl/ap_inflight_cnt.sv
// Saturating up/down count of frames between framing and the statistics stage;
// ovf pulses when an increment arrives at the ceiling.
module ap_inflight_cnt
    import ap_pkg::*;
#(
    parameter int MAX_CNT = AP_MAX_INFLIGHT,
    parameter int W       = AP_INFLIGHT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    logic [W-1:0] cnt_d, cnt_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == W'(MAX_CNT)) ovf = 1'b1;
            else                      cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state updates use <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ap_sequencer.sv
// Audio feature-pipeline controller: capture gating, frame/stat accounting, feature handshake.
// Optional drain watchdog enabled by defining AP_SEQ_WATCHDOG_EN.
module ap_sequencer
    import ap_pkg::*;
#(
    parameter int NUM_FRAMES   = AP_NUM_FRAMES,
    parameter int MAX_INFLIGHT = AP_MAX_INFLIGHT,
`ifdef AP_SEQ_WATCHDOG_EN
    parameter int TIMEOUT_CYC  = 4096,
`endif
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                sample_tick,
    output logic                sample_en,
    input  logic                frame_ready,
    input  logic                stats_valid,
    output logic                fifo_clr,
    output logic                feat_valid,
    input  logic                feat_ready,
    output logic                busy,
    output logic [AP_CNT_W-1:0] frame_cnt,
    output logic                overrun,
    output logic                timeout
);

    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    ap_seq_state_t       state_d, state_q;
    logic [AP_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
    logic [AP_CNT_W-1:0] stats_cnt_d, stats_cnt_q;
    logic                overrun_d, overrun_q;
    logic                sample_en_d, sample_en_q;
    logic                fifo_clr_d, fifo_clr_q;
    logic                feat_valid_d, feat_valid_q;
    logic                busy_d, busy_q;
    logic [INF_W-1:0]    inflight;
    logic                inf_ovf, inf_clr, frame_acc, stats_acc, wd_expire;

    // Events only count in their active states; a stat with nothing in flight is dropped.
    assign frame_acc = (state_q == ST_CAPTURE) && frame_ready && !abort;
    assign stats_acc = ((state_q == ST_CAPTURE) || (state_q == ST_DRAIN)) &&
                       stats_valid && (inflight != '0) && !abort;
    assign inf_clr   = abort || (state_d == ST_CLEAR);

    ap_inflight_cnt #(
        .MAX_CNT (MAX_INFLIGHT),
        .W       (INF_W)
    ) u_inflight (
        .clk (clk),
        .rst (rst),
        .clr (inf_clr),
        .inc (frame_acc),
        .dec (stats_acc),
        .cnt (inflight),
        .ovf (inf_ovf)
    );

`ifdef AP_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt_d, wd_cnt_q;
    logic            timeout_d, timeout_q;

    always_comb begin
        wd_cnt_d  = '0;
        wd_expire = 1'b0;
        if (state_q == ST_DRAIN && !stats_valid && !abort) begin
            wd_cnt_d  = wd_cnt_q + 1'b1;
            wd_expire = (wd_cnt_d == WD_W'(TIMEOUT_CYC));
        end
        timeout_d = (state_d == ST_CLEAR) ? 1'b0 : (timeout_q | wd_expire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_acc ? frame_cnt_q + 1'b1 : frame_cnt_q;
        stats_cnt_d = stats_acc ? stats_cnt_q + 1'b1 : stats_cnt_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_CAPTURE;
            ST_CAPTURE: if (frame_cnt_d == AP_CNT_W'(NUM_FRAMES)) state_d = ST_DRAIN;
            ST_DRAIN:   if (stats_cnt_d == AP_CNT_W'(NUM_FRAMES) || wd_expire) state_d = ST_DONE;
            ST_DONE:    if (feat_valid_q && feat_ready)
                            state_d = AUTO_RESTART ? ST_CLEAR : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
        if (abort || state_d == ST_CLEAR) begin
            frame_cnt_d = '0;
            stats_cnt_d = '0;
        end
    end

    // Outputs are computed from the next state so each one is registered yet lands one clk after its cause.
    always_comb begin
        sample_en_d  = sample_tick && (state_q == ST_CAPTURE) && (state_d == ST_CAPTURE);
        fifo_clr_d   = (state_d == ST_CLEAR);
        feat_valid_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        overrun_d    = (state_d == ST_CLEAR) ? 1'b0 : (overrun_q | inf_ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            stats_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            sample_en_q  <= 1'b0;
            fifo_clr_q   <= 1'b0;
            feat_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            stats_cnt_q  <= stats_cnt_d;
            overrun_q    <= overrun_d;
            sample_en_q  <= sample_en_d;
            fifo_clr_q   <= fifo_clr_d;
            feat_valid_q <= feat_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign sample_en  = sample_en_q;
    assign fifo_clr   = fifo_clr_q;
    assign feat_valid = feat_valid_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule
